// File: rtl/ccc_apb_reconfig_master_if.sv
// APB-style dynamic-configuration bus between the reconfiguration master and the CCC.
// BUSY travels with the bus because it gates when the master may start a transfer.
interface ccc_apb_reconfig_master_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [5:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       busy;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, busy
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, busy
    );
endinterface

// File: rtl/ccc_apb_reconfig_master.sv
// Writes a configuration image into the fabric CCC over APB, optionally reads it back,
// then releases the PLL and qualifies LOCK against a stability window and a timeout.
module ccc_apb_reconfig_master #(
    parameter int         NUM_REGS     = 27,
    parameter logic [5:0] BASE_ADDR    = 6'h00,
    parameter int         LOCK_STABLE  = 16,
    parameter int         LOCK_TIMEOUT = 100000
) (
    input  logic                    pclk_i,
    input  logic                    preset_n_i,
    input  logic                    start_i,
    input  logic                    verify_i,
    input  logic [NUM_REGS*8-1:0]   cfg_image_i,
    ccc_apb_reconfig_master_if.master apb,
    input  logic                    lock_i,
    output logic                    pll_arst_n_o,
    output logic                    cfg_busy_o,
    output logic                    done_o,
    output logic [1:0]              err_code_o
);
    localparam int IDX_W = $clog2(NUM_REGS) + 1;
    localparam int STB_W = $clog2(LOCK_STABLE) + 1;
    localparam int TMO_W = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [STB_W-1:0] STB_LIM  = STB_W'(LOCK_STABLE);
    localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(LOCK_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_BUSY = 4'd1,
        S_WR_SETUP  = 4'd2,
        S_WR_ACCESS = 4'd3,
        S_RD_SETUP  = 4'd4,
        S_RD_ACCESS = 4'd5,
        S_RELEASE   = 4'd6,
        S_WAIT_LOCK = 4'd7,
        S_FINISH    = 4'd8
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  rd_phase_q, rd_phase_d;
    logic                  verify_q, verify_d;
    logic [NUM_REGS*8-1:0] image_q, image_d;
    logic [1:0]            err_q, err_d;
    logic [STB_W-1:0]      stb_q, stb_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [5:0]            paddr_q, paddr_d;
    logic [7:0]            pwdata_q, pwdata_d;
    logic                  pll_q, pll_d;
    logic                  cfg_busy_q, cfg_busy_d;
    logic                  done_q, done_d;

    function automatic logic [7:0] img_byte(input logic [NUM_REGS*8-1:0] img,
                                            input logic [IDX_W-1:0]      idx);
        return 8'(img >> {idx, 3'b000});
    endfunction

    // Sequencer: next state, image/index bookkeeping and lock qualification counters.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_phase_d = rd_phase_q;
        verify_d   = verify_q;
        image_d    = image_q;
        err_d      = err_q;
        stb_d      = stb_q;
        tmo_d      = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    image_d    = cfg_image_i;
                    verify_d   = verify_i;
                    err_d      = 2'b00;
                    idx_d      = '0;
                    rd_phase_d = 1'b0;
                    state_d    = apb.busy ? S_WAIT_BUSY : S_WR_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_BUSY: begin
                if (!apb.busy) begin
                    state_d = rd_phase_q ? S_RD_SETUP : S_WR_SETUP;
                end else begin
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WR_SETUP: state_d = S_WR_ACCESS;
            S_WR_ACCESS: begin
                if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = apb.busy ? S_WAIT_BUSY : S_WR_SETUP;
                end else if (verify_q) begin
                    idx_d      = '0;
                    rd_phase_d = 1'b1;
                    state_d    = apb.busy ? S_WAIT_BUSY : S_RD_SETUP;
                end else begin
                    idx_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RD_SETUP: state_d = S_RD_ACCESS;
            S_RD_ACCESS: begin
                if (apb.prdata != img_byte(image_q, idx_q)) begin
                    err_d   = 2'b10;
                    state_d = S_FINISH;
                end else if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = apb.busy ? S_WAIT_BUSY : S_RD_SETUP;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                stb_d   = '0;
                tmo_d   = '0;
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_i) begin
                    stb_d = (stb_q == '1) ? stb_q : stb_q + STB_ONE;
                end else begin
                    stb_d = '0;
                end
                tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_ONE;
                // Lock is tested first so a simultaneous timeout still reports success.
                if (stb_d >= STB_LIM) begin
                    err_d   = 2'b00;
                    state_d = S_FINISH;
                end else if (tmo_d >= TMO_LIM) begin
                    err_d   = 2'b01;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every port is a flop that tracks the current state.
    always_comb begin
        psel_d     = 1'b0;
        penable_d  = 1'b0;
        pwrite_d   = 1'b0;
        paddr_d    = 6'h00;
        pwdata_d   = 8'h00;
        pll_d      = pll_q;
        cfg_busy_d = 1'b1;
        done_d     = 1'b0;
        case (state_d)
            S_IDLE: cfg_busy_d = 1'b0;
            S_WAIT_BUSY, S_WAIT_LOCK: cfg_busy_d = 1'b1;
            S_WR_SETUP, S_WR_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = (state_d == S_WR_ACCESS);
                pwrite_d  = 1'b1;
                paddr_d   = BASE_ADDR + 6'(idx_d);
                pwdata_d  = img_byte(image_d, idx_d);
                pll_d     = 1'b0;
            end
            S_RD_SETUP, S_RD_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = (state_d == S_RD_ACCESS);
                paddr_d   = BASE_ADDR + 6'(idx_d);
                pll_d     = 1'b0;
            end
            S_RELEASE: pll_d = 1'b1;
            S_FINISH: begin
                cfg_busy_d = 1'b0;
                done_d     = 1'b1;
            end
            default: cfg_busy_d = 1'b0;
        endcase
    end

    // State and registered outputs; reset drops the APB strobes and releases the PLL at once.
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rd_phase_q <= 1'b0;
            verify_q   <= 1'b0;
            image_q    <= '0;
            err_q      <= 2'b00;
            stb_q      <= '0;
            tmo_q      <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= 6'h00;
            pwdata_q   <= 8'h00;
            pll_q      <= 1'b1;
            cfg_busy_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_phase_q <= rd_phase_d;
            verify_q   <= verify_d;
            image_q    <= image_d;
            err_q      <= err_d;
            stb_q      <= stb_d;
            tmo_q      <= tmo_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pll_q      <= pll_d;
            cfg_busy_q <= cfg_busy_d;
            done_q     <= done_d;
        end
    end

    assign apb.psel     = psel_q;
    assign apb.penable  = penable_q;
    assign apb.pwrite   = pwrite_q;
    assign apb.paddr    = paddr_q;
    assign apb.pwdata   = pwdata_q;
    assign pll_arst_n_o = pll_q;
    assign cfg_busy_o   = cfg_busy_q;
    assign done_o       = done_q;
    assign err_code_o   = err_q;
endmodule

// File: tb/tb_ccc_apb_reconfig_master.sv
// Bench for ccc_apb_reconfig_master: a CCC register model answers reads, and each job is
// expanded into an expected cycle-by-cycle timeline from the transfer/lock rules.
module tb_ccc_apb_reconfig_master;
    localparam int         NR      = 2;
    localparam logic [5:0] BASE    = 6'h00;
    localparam int         STABLE  = 16;
    localparam int         TIMEOUT = 50;

    localparam int K_IDLE = 0, K_WAIT = 1, K_SETUP = 2, K_ACCESS = 3, K_REL = 4, K_LOCK = 5, K_FIN = 6;

    typedef struct {
        int          kind;
        logic [21:0] ev;
        logic        busy;
        logic        lock;
    } cyc_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            verify;
    logic            lock;
    logic [NR*8-1:0] image;
    logic            pll;
    logic            cbusy;
    logic            done;
    logic [1:0]      err;

    logic [7:0]      mem [64];
    logic            corrupt_en;
    logic [5:0]      corrupt_addr;

    cyc_t            tl[$];
    int              waits [2*NR];
    logic            pll_m = 1'b1;
    logic [1:0]      err_m = 2'b00;
    int              checks = 0;
    int              errors = 0;
    string           tag;

    ccc_apb_reconfig_master_if apb_if ();

    ccc_apb_reconfig_master #(
        .NUM_REGS(NR), .BASE_ADDR(BASE), .LOCK_STABLE(STABLE), .LOCK_TIMEOUT(TIMEOUT)
    ) dut (
        .pclk_i(clk), .preset_n_i(rst_n), .start_i(start), .verify_i(verify),
        .cfg_image_i(image), .apb(apb_if.master), .lock_i(lock),
        .pll_arst_n_o(pll), .cfg_busy_o(cbusy), .done_o(done), .err_code_o(err)
    );

    always #5 clk = ~clk;

    // CCC register file: stores completed writes, returns stored bytes (or a forced 00) on reads.
    always @(posedge clk) begin
        if (apb_if.psel && apb_if.penable && apb_if.pwrite) mem[apb_if.paddr] <= apb_if.pwdata;
    end
    assign apb_if.prdata = (corrupt_en && apb_if.paddr == corrupt_addr) ? 8'h00 : mem[apb_if.paddr];

    function automatic logic lock_at(input int mode, input int par, input int k);
        case (mode)
            0:       return (k > par);
            1:       return 1'b0;
            2:       return (((k - 1) / 10) % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [NR*8-1:0] rand_img();
        logic [NR*8-1:0] v;
        for (int j = 0; j < NR; j++) v[8*j +: 8] = 8'($urandom);
        return v;
    endfunction

    task automatic push(input int k, input logic ps, input logic pe, input logic pw,
                        input logic [5:0] a, input logic [7:0] d, input logic cb, input logic dn);
        cyc_t e;
        e.kind = k;
        e.ev   = {ps, pe, pw, a, d, pll_m, cb, dn, err_m};
        e.busy = 1'b0;
        e.lock = 1'b0;
        tl.push_back(e);
    endtask

    // BUSY is high exactly where the next cycle must be a wait; elsewhere it is don't-care or low.
    task automatic fill_inputs();
        for (int c = 0; c < tl.size(); c++) begin
            if (c + 1 < tl.size() && tl[c+1].kind == K_WAIT) tl[c].busy = 1'b1;
            else if (tl[c].kind == K_SETUP || tl[c].kind == K_REL || tl[c].kind == K_LOCK)
                tl[c].busy = 1'($urandom_range(0, 1));
            else tl[c].busy = 1'b0;
            if (tl[c].kind != K_LOCK && tl[c].kind != K_IDLE && tl[c].kind != K_FIN)
                tl[c].lock = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic build(input logic [NR*8-1:0] img, input logic vfy, input int bad,
                         input int lmode, input int lpar);
        int   nt;
        int   run;
        int   i;
        logic rd;
        logic l;
        tl.delete();
        push(K_IDLE, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
        err_m = 2'b00;
        nt = vfy ? 2 * NR : NR;
        for (int t = 0; t < nt; t++) begin
            rd = (t >= NR);
            i  = t % NR;
            for (int w = 0; w < waits[t]; w++) push(K_WAIT, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0);
            pll_m = 1'b0;
            push(K_SETUP,  1'b1, 1'b0, !rd, BASE + 6'(i), rd ? 8'h00 : img[8*i +: 8], 1'b1, 1'b0);
            push(K_ACCESS, 1'b1, 1'b1, !rd, BASE + 6'(i), rd ? 8'h00 : img[8*i +: 8], 1'b1, 1'b0);
            if (rd && i == bad) begin
                err_m = 2'b10;
                push(K_FIN,  1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b1);
                push(K_IDLE, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
                fill_inputs();
                return;
            end
        end
        pll_m = 1'b1;
        push(K_REL, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0);
        run = 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            l = lock_at(lmode, lpar, k);
            push(K_LOCK, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0);
            tl[tl.size()-1].lock = l;
            run = l ? run + 1 : 0;
            if (run >= STABLE) break;
            if (k == TIMEOUT) err_m = 2'b01;
        end
        push(K_FIN,  1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b1);
        push(K_IDLE, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
        fill_inputs();
    endtask

    task automatic check(input int c);
        logic [21:0] obs;
        obs = {apb_if.psel, apb_if.penable, apb_if.pwrite, apb_if.paddr, apb_if.pwdata,
               pll, cbusy, done, err};
        checks++;
        assert (obs === tl[c].ev) else begin
            errors++;
            $error("FAIL %s cyc%0d kind%0d observed=%h expected=%h", tag, c, tl[c].kind, obs, tl[c].ev);
        end
    endtask

    // Called #1 after a clock edge with the DUT idle; START is sampled at the next edge.
    task automatic run(input logic [NR*8-1:0] img, input logic vfy, input int restart_at, input int stop_at);
        int last;
        last = (stop_at < tl.size()) ? stop_at : tl.size() - 1;
        start = 1'b1; image = img; verify = vfy;
        apb_if.busy = tl[0].busy; lock = tl[0].lock;
        check(0);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            start = (c == restart_at);
            if (c == 1) begin
                image  = rand_img();
                verify = !vfy;
            end
            apb_if.busy = tl[c].busy;
            lock        = tl[c].lock;
            check(c);
        end
        start = 1'b0;
    endtask

    task automatic clear_waits();
        for (int t = 0; t < 2*NR; t++) waits[t] = 0;
    endtask

    initial begin
        logic [NR*8-1:0] img;
        logic            vfy;
        int              bad;
        int              mode;
        rst_n = 1'b0; start = 1'b0; verify = 1'b0; image = '0; lock = 1'b0;
        apb_if.busy = 1'b0; corrupt_en = 1'b0; corrupt_addr = 6'h00;
        clear_waits();
        tl.delete();
        push(K_IDLE, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1; tag = "reset"; check(0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        tag = "wr_lock3";     build(16'hA55A, 1'b0, -1, 0, 3);  run(16'hA55A, 1'b0, -1, 1000);
        tag = "verify_echo";  build(16'hA55A, 1'b1, -1, 0, 3);  run(16'hA55A, 1'b1, -1, 1000);
        corrupt_en = 1'b1; corrupt_addr = BASE + 6'd1;
        tag = "verify_miss";  build(16'hA55A, 1'b1, 1, 0, 0);   run(16'hA55A, 1'b1, -1, 1000);
        corrupt_en = 1'b0;
        tag = "timeout_low";  build(16'h1234, 1'b0, -1, 1, 0);  run(16'h1234, 1'b0, -1, 1000);
        tag = "timeout_togl"; build(16'h8001, 1'b0, -1, 2, 0);  run(16'h8001, 1'b0, -1, 1000);
        tag = "lock_ties_to"; build(16'h00FF, 1'b0, -1, 0, 34); run(16'h00FF, 1'b0, -1, 1000);
        tag = "lock_late";    build(16'hFF00, 1'b0, -1, 0, 35); run(16'hFF00, 1'b0, -1, 1000);
        waits[0] = 5; waits[1] = 2;
        tag = "busy_restart"; build(16'h3CC3, 1'b0, -1, 0, 0);  run(16'h3CC3, 1'b0, 7, 1000);
        waits[2] = 1;
        tag = "busy_verify";  build(16'h7E81, 1'b1, -1, 0, 5);  run(16'h7E81, 1'b1, -1, 1000);

        for (int j = 0; j < 10; j++) begin
            clear_waits();
            for (int t = 0; t < 2*NR; t++) waits[t] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            img  = rand_img();
            vfy  = 1'($urandom_range(0, 1));
            bad  = -1;
            if (vfy && $urandom_range(0, 2) == 0) begin
                bad = $urandom_range(0, NR - 1);
                img[8*bad +: 8] = img[8*bad +: 8] | 8'h01;
                corrupt_en = 1'b1; corrupt_addr = BASE + 6'(bad);
            end
            mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
            tag = $sformatf("rand%0d", j);
            build(img, vfy, bad, mode, $urandom_range(0, 40));
            run(img, vfy, ($urandom_range(0, 1) == 1) ? 2 : -1, 1000);
            corrupt_en = 1'b0;
        end

        clear_waits();
        img = rand_img();
        tag = "pre_rst"; build(img, 1'b0, -1, 0, 0); run(img, 1'b0, -1, 4);
        #2 rst_n = 1'b0;
        #1;
        tl.delete(); pll_m = 1'b1; err_m = 2'b00;
        push(K_IDLE, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
        tag = "async_rst"; check(0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        img = rand_img();
        tag = "post_rst"; build(img, 1'b1, -1, 0, 2); run(img, 1'b1, -1, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ccc_apb_reconfig_master.md
# ccc_apb_reconfig_master

APB initiator that drives the dynamic-configuration port of the fabric CCC (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA, BUSY, PLL_ARST_N, LOCK). On request it writes a configuration image byte by byte, optionally reads it back for verification, releases the PLL and qualifies LOCK with a stability window and a timeout. It sits in the Filterwheel system block beside the CCC and lets firmware retune the fabric clock at run time without a rebuild.

## Interface
- NUM_REGS, 27: number of 8-bit CCC configuration registers written per image.
- BASE_ADDR, 6'h00: PADDR of image byte 0; byte i goes to BASE_ADDR+i (6-bit, wraps modulo 64).
- LOCK_STABLE, 16: consecutive LOCK-high cycles required to declare lock.
- LOCK_TIMEOUT, 100000: maximum cycles in WAIT_LOCK before declaring failure.

- PCLK  in  1  clock for all logic and the APB port.
- PRESET_N  in  1  asynchronous, active-low reset.
- START  in  1  request pulse; sampled only in IDLE.
- VERIFY  in  1  latched with START; 1 enables the readback phase.
- CFG_IMAGE  in  NUM_REGS*8  image; byte i = CFG_IMAGE[8i+7:8i]; latched with START.
- PSEL, PENABLE, PWRITE  out  1  APB controls to the CCC.
- PADDR  out  6  APB address.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data from the CCC.
- BUSY  in  1  CCC busy; no transfer starts while high.
- PLL_ARST_N  out  1  active-low PLL reset to the CCC.
- LOCK  in  1  CCC PLL lock, treated as synchronous to PCLK.
- CFG_BUSY  out  1  high from the cycle after START acceptance until DONE.
- DONE  out  1  single-cycle completion pulse (success or failure).
- ERR_CODE  out  2  00 ok, 01 lock timeout, 10 verify mismatch; held until next accepted START.

## Operation
- States: IDLE, WAIT_BUSY, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, RELEASE, WAIT_LOCK, FINISH.
- IDLE: START=1 latches CFG_IMAGE and VERIFY, clears ERR_CODE, sets index=0, phase=write; next state WR_SETUP if BUSY=0, else WAIT_BUSY. START in any other state is ignored.
- WAIT_BUSY: PSEL=0; leave to the pending SETUP state on the first cycle BUSY is sampled 0.
- WR_SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR=BASE_ADDR+index, PWDATA=byte[index], PLL_ARST_N=0. Always → WR_ACCESS.
- WR_ACCESS: same plus PENABLE=1. Next: if index<NUM_REGS-1, increment and go to WR_SETUP (or WAIT_BUSY if BUSY=1); else index=0 and go to RD_SETUP/WAIT_BUSY if VERIFY, otherwise RELEASE.
- RD_SETUP/RD_ACCESS: as the write states but PWRITE=0, PWDATA=0; PRDATA is sampled at the end of RD_ACCESS and compared to byte[index]. Mismatch → ERR_CODE=10, FINISH, with PLL_ARST_N kept low. Match on the last index → RELEASE.
- RELEASE: PSEL=0, PLL_ARST_N=1, clear the stable and timeout counters. Always → WAIT_LOCK.
- WAIT_LOCK: stable counter increments while LOCK=1 and clears on LOCK=0; timeout counter increments every cycle. Stable count reaching LOCK_STABLE → FINISH with ERR_CODE=00. Timeout reaching LOCK_TIMEOUT first → ERR_CODE=01, FINISH. If both occur in the same cycle, lock wins.
- FINISH: DONE=1 for one cycle, CFG_BUSY=0, → IDLE.
- PLL_ARST_N is low from the first WR_SETUP until RELEASE. After a verify mismatch it stays low until a later successful RELEASE.
- Counters are sized by $clog2 of their parameter plus 1. They saturate and never wrap.

## Timing
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PLL_ARST_N=1, CFG_BUSY=0, DONE=0, ERR_CODE=00, state IDLE. The APB outputs are registered, so a mid-transfer reset drops PSEL/PENABLE asynchronously.
- START accepted at edge N → WR_SETUP visible in cycle N+1 when BUSY=0.
- Each transfer takes exactly 2 cycles (setup, access), plus 1 cycle per cycle of BUSY=1 sampled before a setup.
- With BUSY=0 and no verify, RELEASE is cycle N+1+2·NUM_REGS. Verify adds 2·NUM_REGS cycles.
- DONE occurs no earlier than RELEASE+1+LOCK_STABLE.
- BUSY going high during an access phase does not stretch that transfer; it only delays the next setup.

## Test plan
- NUM_REGS=2, image 16'hA55A, VERIFY=0, BUSY=0, LOCK high 3 cycles after RELEASE → writes (addr 0, 5A) then (addr 1, A5), 2 cycles each; PLL_ARST_N low for 4 cycles; DONE at RELEASE+1+3+16, ERR_CODE=00.
- Same with VERIFY=1 and PRDATA echoing the writes → 4 read cycles follow the writes; DONE with ERR_CODE=00.
- VERIFY=1, PRDATA returns 8'h00 for addr 1 → FINISH right after the second read; ERR_CODE=10; PLL_ARST_N stays 0 and RELEASE never occurs.
- LOCK_TIMEOUT=50, LOCK held 0 → DONE exactly 50 cycles into WAIT_LOCK with ERR_CODE=01. Then, with LOCK toggling every 10 cycles and LOCK_STABLE=16, expect the same timeout.
- BUSY=1 for 5 cycles at START → PSEL stays 0 for those 5 cycles; the first setup comes in the cycle after BUSY is sampled 0. A second START mid-write is ignored.
- PRESET_N asserted during WR_ACCESS of byte 1 → all outputs reach reset values immediately (PLL_ARST_N=1, PSEL=0); a fresh START afterwards restarts from byte 0.
